// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command sequencer:
// select encodings, default widths and the sequencer state encoding.
package alu_pkg;

    localparam int DW_DEF = 4;
    localparam int SW_DEF = 3;
    localparam int CW_DEF = 8;

    localparam logic [SW_DEF-1:0] ALU_ADD = 3'd0;
    localparam logic [SW_DEF-1:0] ALU_SUB = 3'd1;
    localparam logic [SW_DEF-1:0] ALU_AND = 3'd2;
    localparam logic [SW_DEF-1:0] ALU_OR  = 3'd3;
    localparam logic [SW_DEF-1:0] ALU_XOR = 3'd4;
    localparam logic [SW_DEF-1:0] ALU_NOT = 3'd5;
    localparam logic [SW_DEF-1:0] ALU_SHR = 3'd6;
    localparam logic [SW_DEF-1:0] ALU_SHL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response channels of the ALU command sequencer.
// master = command source / ALU side, slave = the sequencer.
interface alu_cmd_sequencer_if
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF,
    parameter int CW = CW_DEF
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [SW-1:0] cmd_sel;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic          cmd_use_acc;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [SW-1:0] alu_select;
    logic [DW-1:0] alu_result;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero;

    logic [DW-1:0] acc;
    logic [CW-1:0] op_count;

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc,
        output alu_result,
        output rsp_ready,
        input  cmd_ready,
        input  alu_a, alu_b, alu_select,
        input  rsp_valid, rsp_result, rsp_zero,
        input  acc, op_count
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc,
        input  alu_result,
        input  rsp_ready,
        output cmd_ready,
        output alu_a, alu_b, alu_select,
        output rsp_valid, rsp_result, rsp_zero,
        output acc, op_count
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues one command at a time to an external combinational ALU, captures
// the result into an accumulator and returns it on a valid/ready channel.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_sequencer_if.slave   bus
);

    seq_state_e    r_state;
    seq_state_e    w_state_nxt;

    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [SW-1:0] r_alu_sel;
    logic [DW-1:0] r_rsp_result;
    logic          r_rsp_zero;
    logic [DW-1:0] r_acc;
    logic [CW-1:0] r_op_count;

    logic          w_cmd_ready;
    logic          w_rsp_valid;
    logic          w_cmd_fire;
    logic          w_rsp_fire;

    assign w_cmd_fire = bus.cmd_valid && w_cmd_ready;
    assign w_rsp_fire = w_rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cmd_fire) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_rsp_fire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of state, so cmd_ready never
    // looks at cmd_valid and a command cannot overlap a consumed response.
    always_comb begin
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE:    w_cmd_ready = 1'b1;
            RESP:    w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
        end else if (w_cmd_fire) begin
            r_alu_a   <= bus.cmd_use_acc ? r_acc : bus.cmd_a;
            r_alu_b   <= bus.cmd_b;
            r_alu_sel <= bus.cmd_sel;
        end
    end

    // The ALU operands are registered, so its result is settled for the
    // whole EXEC cycle and can be captured at the end of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b1;
            r_acc        <= '0;
        end else if (r_state == EXEC) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_zero   <= (bus.alu_result == '0);
            r_acc        <= bus.alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_rsp_fire) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_select = r_alu_sel;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.acc        = r_acc;
    assign bus.op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised self-checking bench for alu_cmd_sequencer with a behavioural
// ALU and a transaction-level reference model (accumulator + counter).
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.DW(4), .SW(3), .CW(8)) bus ();

    alu_cmd_sequencer #(.DW(4), .SW(3), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU standing in for the real combinational ALU instance.
    always_comb begin
        case (bus.alu_select)
            3'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
            3'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
            3'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
            3'd3:    bus.alu_result = bus.alu_a | bus.alu_b;
            3'd4:    bus.alu_result = bus.alu_a ^ bus.alu_b;
            3'd5:    bus.alu_result = ~bus.alu_a;
            3'd6:    bus.alu_result = bus.alu_a >> 1;
            default: bus.alu_result = bus.alu_a << 1;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int m_acc;
    int m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_op(input int sel, input int a, input int b);
        case (sel)
            0:       return (a + b) % 16;
            1:       return (a + 16 - b) % 16;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return 15 - a;
            6:       return a / 2;
            default: return (a * 2) % 16;
        endcase
    endfunction

    task automatic drive_idle();
        bus.cmd_valid   = 1'b0;
        bus.cmd_sel     = '0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.cmd_use_acc = 1'b0;
        bus.rsp_ready   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        m_acc   = 0;
        m_count = 0;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_alu_a", 32'(bus.alu_a), 0);
        check("rst_alu_b", 32'(bus.alu_b), 0);
        check("rst_alu_select", 32'(bus.alu_select), 0);
        check("rst_rsp_result", 32'(bus.rsp_result), 0);
        check("rst_rsp_zero", 32'(bus.rsp_zero), 1);
        check("rst_acc", 32'(bus.acc), 0);
        check("rst_op_count", 32'(bus.op_count), 0);
        rst_n = 1'b1;
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge
    // after the response handshake. t_valid = cycle rsp_valid was first seen.
    task automatic run_cmd(input int sel, input int a, input int b, input bit use_acc,
                           input int stall, input bit poke, output int t_valid);
        int exp_a;
        int exp_r;
        check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_sel     = 3'(sel);
        bus.cmd_a       = 4'(a);
        bus.cmd_b       = 4'(b);
        bus.cmd_use_acc = use_acc;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        exp_a = use_acc ? m_acc : a;
        exp_r = ref_op(sel, exp_a, b);
        check("exec_alu_a", 32'(bus.alu_a), 32'(exp_a));
        check("exec_alu_b", 32'(bus.alu_b), 32'(b));
        check("exec_alu_select", 32'(bus.alu_select), 32'(sel));
        check("exec_cmd_ready", 32'(bus.cmd_ready), 0);
        check("exec_rsp_valid", 32'(bus.rsp_valid), 0);
        @(posedge clk);
        @(negedge clk);
        t_valid = cyc;
        m_acc = exp_r;
        check("rsp_valid", 32'(bus.rsp_valid), 1);
        check("rsp_result", 32'(bus.rsp_result), 32'(exp_r));
        check("rsp_zero", 32'(bus.rsp_zero), (exp_r == 0) ? 1 : 0);
        check("rsp_acc", 32'(bus.acc), 32'(exp_r));
        check("rsp_cmd_ready", 32'(bus.cmd_ready), 0);
        for (int i = 0; i < stall; i++) begin
            bus.rsp_ready = 1'b0;
            if (poke && i == 1) begin
                bus.cmd_valid   = 1'b1;
                bus.cmd_sel     = 3'($urandom_range(0, 7));
                bus.cmd_a       = 4'($urandom_range(0, 15));
                bus.cmd_b       = 4'($urandom_range(0, 15));
                bus.cmd_use_acc = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            check("stall_rsp_valid", 32'(bus.rsp_valid), 1);
            check("stall_rsp_result", 32'(bus.rsp_result), 32'(exp_r));
            check("stall_cmd_ready", 32'(bus.cmd_ready), 0);
            check("stall_alu_a", 32'(bus.alu_a), 32'(exp_a));
            check("stall_op_count", 32'(bus.op_count), 32'(m_count));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        m_count = (m_count + 1) % 256;
        check("done_rsp_valid", 32'(bus.rsp_valid), 0);
        check("done_op_count", 32'(bus.op_count), 32'(m_count));
        check("done_cmd_ready", 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t_prev;
        apply_reset();

        run_cmd(int'(ALU_ADD), 5, 3, 1'b0, 0, 1'b0, t);
        run_cmd(int'(ALU_SUB), 2, 3, 1'b0, 0, 1'b0, t);
        run_cmd(int'(ALU_XOR), 15, 15, 1'b0, 0, 1'b0, t);
        run_cmd(int'(ALU_ADD), 4, 1, 1'b0, 0, 1'b0, t);
        run_cmd(int'(ALU_SHL), 0, 0, 1'b1, 0, 1'b0, t);
        run_cmd(int'(ALU_NOT), 0, 0, 1'b1, 0, 1'b0, t);
        check("chain_not_result", 32'(bus.rsp_result), 32'h5);

        run_cmd(int'(ALU_ADD), 7, 6, 1'b0, 5, 1'b1, t);

        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), 1'b0, t);
        end

        // Reset while a command is in EXEC: it must vanish without a trace.
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = ALU_AND;
        bus.cmd_a     = 4'hC;
        bus.cmd_b     = 4'hA;
        bus.cmd_use_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("midrst_exec_alu_a", 32'(bus.alu_a), 32'hC);
        #2 rst_n = 1'b0;
        #1;
        m_acc   = 0;
        m_count = 0;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("midrst_acc", 32'(bus.acc), 0);
        check("midrst_op_count", 32'(bus.op_count), 0);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(int'(ALU_OR), 12, 3, 1'b0, 0, 1'b0, t);
        check("midrst_or_result", 32'(bus.rsp_result), 32'hF);

        apply_reset();
        t_prev = -1;
        for (int i = 0; i < 256; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    0, 1'b0, t);
            if (t_prev >= 0) check("b2b_spacing", 32'(t - t_prev), 3);
            t_prev = t;
        end
        check("wrap_op_count", 32'(bus.op_count), 32'(m_count));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
